quadrature_decoder: RTL and testbench

Decodes the motor's A/B/I quadrature encoder into a 13-bit mechanical position (0..8191), a per-electrical-cycle position (0..1169) and a rotation direction. It is the producer of the `encoder_ticks` / `direction` pair consumed by the torque-vector stage of the BLDC velocity controller, and it supplies the already-reduced electrical position that stage's output must otherwise be modded into. Inputs are asynchronous pins; all outputs are registered in the `clk` domain.

---
 rtl/bldc_pkg.sv | 25 ++
 rtl/sync_ff.sv | 26 ++
 rtl/quadrature_decoder.sv | 123 ++++++++++++
 tb/tb_quadrature_decoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bldc_pkg.sv
// Shared BLDC types and constants: encoder/electrical position widths and modulo helpers.
// Pure declarations, no latency; no flow control.
// Used by both the quadrature decoder and the torque-vector stage.
package bldc_pkg;

  localparam int TICKS_PER_REV    = 8192;
  localparam int TICKS_PER_ECYCLE = 1170;

  typedef logic [12:0] enc_pos_t;
  typedef logic [10:0] elec_pos_t;

  localparam elec_pos_t ELEC_MAX = elec_pos_t'(TICKS_PER_ECYCLE - 1);

  // Electrical position is its own modulo-1170 counter, never a division of encoder ticks.
  function automatic elec_pos_t elec_step(input elec_pos_t e, input logic fwd);
    if (fwd) return (e == ELEC_MAX) ? '0 : e + elec_pos_t'(1);
    else     return (e == '0) ? ELEC_MAX : e - elec_pos_t'(1);
  endfunction

  // AB = {a,b} mapped onto its forward-sequence index 00,10,11,01 -> 0..3.
  function automatic logic [1:0] ab_phase(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer for an asynchronous pin, async active-low reset to 0.
// Latency N clk cycles; no flow control.
// Output is the last stage only.
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] stages_q, stages_d;

  always_comb begin
    stages_d = {stages_q[N-2:0], d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stages_q <= '0;
    else          stages_q <= stages_d;
  end

  assign q = stages_q[N-1];

endmodule

// File: rtl/quadrature_decoder.sv
// A/B/I quadrature decoder: mechanical (mod 8192) and electrical (mod 1170) position, direction, error.
// Latency pin edge -> outputs SYNC_STAGES+1 clk; no backpressure, one AB change per clk max.
// QUAD_INDEX_EN: index rising edge at AB=11 zeroes both positions.
module quadrature_decoder
  import bldc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      enc_a,
  input  logic      enc_b,
  input  logic      enc_i,
  input  logic      clear_error,
  output enc_pos_t  encoder_ticks,
  output elec_pos_t elec_ticks,
  output logic      direction,
  output logic      tick_valid,
  output logic      quad_error
);

  // Priming spans the synchronizer flush so the pin level present at reset is what prev_ab learns.
  localparam int PRIME_CYCLES = SYNC_STAGES + 1;
  localparam int PC_W         = $clog2(PRIME_CYCLES + 1);

  logic a_s, b_s, i_s;
  logic [1:0] cur_ab;
  logic [1:0] delta;
  logic       priming;

  logic [1:0]      prev_ab_q, prev_ab_d;
  logic [PC_W-1:0] prime_q, prime_d;
  enc_pos_t        enc_ticks_q, enc_ticks_d;
  elec_pos_t       elec_ticks_q, elec_ticks_d;
  logic            direction_q, direction_d;
  logic            tick_valid_q, tick_valid_d;
  logic            quad_error_q, quad_error_d;

  sync_ff #(.N(SYNC_STAGES)) u_sync_a (.clk(clk), .reset_n(reset_n), .d(enc_a), .q(a_s));
  sync_ff #(.N(SYNC_STAGES)) u_sync_b (.clk(clk), .reset_n(reset_n), .d(enc_b), .q(b_s));
  sync_ff #(.N(SYNC_STAGES)) u_sync_i (.clk(clk), .reset_n(reset_n), .d(enc_i), .q(i_s));

`ifdef QUAD_INDEX_EN
  logic i_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) i_prev_q <= 1'b0;
    else          i_prev_q <= i_s;
  end
`else
  logic unused_enc_i;
  assign unused_enc_i = i_s;
`endif

  assign cur_ab  = {a_s, b_s};
  assign priming = (prime_q != '0);
  assign delta   = ab_phase(cur_ab) - ab_phase(prev_ab_q);

  always_comb begin
    prev_ab_d    = cur_ab;
    prime_d      = priming ? prime_q - PC_W'(1) : prime_q;
    enc_ticks_d  = enc_ticks_q;
    elec_ticks_d = elec_ticks_q;
    direction_d  = direction_q;
    tick_valid_d = 1'b0;
    quad_error_d = quad_error_q & ~clear_error;

    if (!priming) begin
      case (delta)
        2'd1: begin
          enc_ticks_d  = enc_ticks_q + enc_pos_t'(1);
          elec_ticks_d = elec_step(elec_ticks_q, 1'b1);
          direction_d  = 1'b1;
          tick_valid_d = 1'b1;
        end
        2'd3: begin
          enc_ticks_d  = enc_ticks_q - enc_pos_t'(1);
          elec_ticks_d = elec_step(elec_ticks_q, 1'b0);
          direction_d  = 1'b0;
          tick_valid_d = 1'b1;
        end
        2'd2: quad_error_d = 1'b1;
        default: ;
      endcase

`ifdef QUAD_INDEX_EN
      if (i_s && !i_prev_q && cur_ab == 2'b11) begin
        enc_ticks_d  = '0;
        elec_ticks_d = '0;
        direction_d  = direction_q;
        tick_valid_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_ab_q    <= 2'b00;
      prime_q      <= PC_W'(PRIME_CYCLES);
      enc_ticks_q  <= '0;
      elec_ticks_q <= '0;
      direction_q  <= 1'b1;
      tick_valid_q <= 1'b0;
      quad_error_q <= 1'b0;
    end else begin
      prev_ab_q    <= prev_ab_d;
      prime_q      <= prime_d;
      enc_ticks_q  <= enc_ticks_d;
      elec_ticks_q <= elec_ticks_d;
      direction_q  <= direction_d;
      tick_valid_q <= tick_valid_d;
      quad_error_q <= quad_error_d;
    end
  end

  assign encoder_ticks = enc_ticks_q;
  assign elec_ticks    = elec_ticks_q;
  assign direction     = direction_q;
  assign tick_valid    = tick_valid_q;
  assign quad_error    = quad_error_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder: net signed step count is the reference; positions are its modulos.
module tb_quadrature_decoder;
  import bldc_pkg::*;

  logic      clk = 1'b0;
  logic      reset_n = 1'b0;
  logic      enc_a = 1'b0, enc_b = 1'b0, enc_i = 1'b0, clear_error = 1'b0;
  enc_pos_t  encoder_ticks;
  elec_pos_t elec_ticks;
  logic      direction, tick_valid, quad_error;

  int   total = 0;
  int   bad = 0;
  int   net = 0;      // signed count of legal steps since last zeroing
  int   ph = 0;       // pin phase in the forward sequence 00,10,11,01
  logic exp_dir = 1'b1;

  always #5 clk = ~clk;

  quadrature_decoder dut (
    .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .enc_i(enc_i),
    .clear_error(clear_error), .encoder_ticks(encoder_ticks), .elec_ticks(elec_ticks),
    .direction(direction), .tick_valid(tick_valid), .quad_error(quad_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pmod(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  function automatic logic [1:0] ph2ab(input int p);
    case (p)
      0: return 2'b00;
      1: return 2'b10;
      2: return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic check_pos(input string tag);
    check({tag, "_enc"},  encoder_ticks, pmod(net, TICKS_PER_REV));
    check({tag, "_elec"}, elec_ticks,    pmod(net, TICKS_PER_ECYCLE));
    check({tag, "_dir"},  direction,     exp_dir);
  endtask

  // d = +1 forward, -1 reverse, 0 hold; expects exactly one pulse 3 cycles after a step
  task automatic do_step(input int d);
    int first = 0;
    int cnt = 0;
    @(negedge clk);
    ph = pmod(ph + d, 4);
    {enc_a, enc_b} = ph2ab(ph);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (tick_valid) begin
        cnt++;
        if (first == 0) first = k;
      end
    end
    if (d != 0) begin
      net += d;
      exp_dir = (d > 0);
      check("step_lat", first, 3);
      check("step_cnt", cnt, 1);
    end else begin
      check("hold_cnt", cnt, 0);
    end
    check_pos("step");
  endtask

  task automatic quiet(input int n, input string tag);
    int cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (tick_valid) cnt++;
    end
    check({tag, "_no_tick"}, cnt, 0);
  endtask

  initial begin
    int first;
    int cnt;

    // reset with AB=11 held: priming must absorb it
    ph = 2;
    {enc_a, enc_b} = ph2ab(ph);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    quiet(10, "prime");
    check("prime_err", quad_error, 0);
    check("prime_enc", encoder_ticks, 0);
    check("prime_elec", elec_ticks, 0);
    check("prime_dir", direction, 1);

    repeat (4) do_step(1);
    check("fwd4_enc", encoder_ticks, 4);
    check("fwd4_elec", elec_ticks, 4);

    repeat (150) begin
      int r;
      r = $urandom_range(0, 2);
      do_step(r - 1);
    end
    while (net != 300) do_step(net < 300 ? 1 : -1);

    // asynchronous reset mid-rotation
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_enc", encoder_ticks, 0);
    check("arst_elec", elec_ticks, 0);
    check("arst_dir", direction, 1);
    check("arst_tick", tick_valid, 0);
    check("arst_err", quad_error, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    net = 0;
    exp_dir = 1'b1;
    quiet(10, "rst2");
    check("rst2_err", quad_error, 0);

    do_step(-1);
    check("rev_enc", encoder_ticks, 8191);
    check("rev_elec", elec_ticks, 1169);
    check("rev_dir", direction, 0);
    do_step(1);
    repeat (1170) do_step(1);
    check("ecyc_elec", elec_ticks, 0);
    check("ecyc_enc", encoder_ticks, 1170);

    // illegal 00 -> 11
    while (ph != 0) do_step(1);
    @(negedge clk);
    ph = 2;
    {enc_a, enc_b} = ph2ab(ph);
    quiet(6, "ill");
    check("ill_err", quad_error, 1);
    check_pos("ill");

    // illegal 10 -> 01 decoded in the same cycle as clear_error
    do_step(-1);
    @(negedge clk);
    ph = 3;
    {enc_a, enc_b} = ph2ab(ph);
    @(negedge clk);
    @(negedge clk);
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    check("clr_vs_ill_err", quad_error, 1);
    quiet(4, "ill2");
    check_pos("ill2");
    @(negedge clk);
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    check("clr_err", quad_error, 0);
    do_step(1);

    // index pulse at AB=11 near position 500
    while (net != 500) do_step(net < 500 ? 1 : -1);
    while (ph != 2) do_step(1);
    @(negedge clk);
    enc_i = 1'b1;
    first = 0;
    cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (tick_valid) begin
        cnt++;
        if (first == 0) first = k;
      end
    end
    enc_i = 1'b0;
`ifdef QUAD_INDEX_EN
    check("idx_lat", first, 3);
    check("idx_cnt", cnt, 1);
    net = 0;
`else
    check("idx_cnt", cnt, 0);
`endif
    check_pos("idx");
    quiet(4, "idx_fall");
    do_step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
